// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER data-hazard unit.
//   opcode_t    : RV32I major opcodes that matter for register use
//   state_t     : stall FSM states
//   fwd_sel_t   : operand-forward select encoding
//   NOP_INSTR   : canonical bubble (addi x0,x0,0)
//   uses_rs1 / uses_rs2 / writes_rd : register-use decode from an instruction word
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Stage indices into the per-stage decode arrays
    localparam int STG_DEC = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field, not a register
    function automatic logic uses_rs1(input logic [31:0] ir);
        logic r;
        r = 1'b0;
        case (ir[6:0])
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: r = 1'b1;
            OPC_SYSTEM: r = ~ir[14];
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        logic r;
        r = 1'b0;
        case (ir[6:0])
            OPC_BRANCH, OPC_STORE, OPC_OP: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // funct3=0 under SYSTEM is ecall/ebreak/mret, which write no register
    function automatic logic writes_rd(input logic [31:0] ir);
        logic r;
        r = 1'b0;
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP: r = 1'b1;
            OPC_SYSTEM: r = (ir[14:12] != 3'b000);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/otter_reg_use.sv
// Combinational register-use decoder for one pipeline stage.
//   ir       in  32      instruction word
//   rs1/rs2  out REG_AW  source register fields
//   rd       out REG_AW  destination register field
//   rs1_used out 1       instruction reads rs1
//   rs2_used out 1       instruction reads rs2
//   rd_valid out 1       instruction writes a non-x0 rd (x0 writes can never cause a hazard)
module otter_reg_use
    import otter_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       ir,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic              rs1_used,
    output logic              rs2_used,
    output logic              rd_valid
);

    assign rs1      = ir[15 +: REG_AW];
    assign rs2      = ir[20 +: REG_AW];
    assign rd       = ir[7  +: REG_AW];
    assign rs1_used = uses_rs1(ir);
    assign rs2_used = uses_rs2(ir);
    assign rd_valid = writes_rd(ir) && (rd != '0);

    logic unused_ir;
    assign unused_ir = ^ir[31:25];

endmodule

// File: rtl/otter_hazard_unit.sv
// Data-hazard unit for the 5-stage OTTER pipeline.
//   clk, rst              clock / asynchronous active-high reset
//   dec_ir..wb_ir         instructions currently in DEC, EX, MEM, WB
//   br_flush              taken branch/jump resolved in EX
//   pc_write, dec_en      PC / IF-DEC load enables
//   ex_flush              load a bubble into DEC/EX this edge
//   fwd_a_sel, fwd_b_sel  registered operand-forward selects for the instr in EX
//   stalled               stall FSM is in STALL
//   stall_cycles          saturating count of cycles with pc_write=0
module otter_hazard_unit
    import otter_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dec_ir,
    input  logic [31:0]       ex_ir,
    input  logic [31:0]       mem_ir,
    input  logic [31:0]       wb_ir,
    input  logic              br_flush,
    output logic              pc_write,
    output logic              dec_en,
    output logic              ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stalled,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [31:0]       stage_ir   [4];
    logic [REG_AW-1:0] rs1_arr    [4];
    logic [REG_AW-1:0] rs2_arr    [4];
    logic [REG_AW-1:0] rd_arr     [4];
    logic              rs1_u_arr  [4];
    logic              rs2_u_arr  [4];
    logic              rd_v_arr   [4];
    logic              hit        [4];

    assign stage_ir[STG_DEC] = dec_ir;
    assign stage_ir[STG_EX]  = ex_ir;
    assign stage_ir[STG_MEM] = mem_ir;
    assign stage_ir[STG_WB]  = wb_ir;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_use
            otter_reg_use #(.REG_AW(REG_AW)) u_use (
                .ir       (stage_ir[gi]),
                .rs1      (rs1_arr[gi]),
                .rs2      (rs2_arr[gi]),
                .rd       (rd_arr[gi]),
                .rs1_used (rs1_u_arr[gi]),
                .rs2_used (rs2_u_arr[gi]),
                .rd_valid (rd_v_arr[gi])
            );
        end

        // hit[p]: some source actually read by DEC is produced by stage p
        assign hit[STG_DEC] = 1'b0;
        for (gi = 1; gi < 4; gi++) begin : g_hit
            assign hit[gi] = rd_v_arr[gi] &&
                ((rs1_u_arr[STG_DEC] && (rs1_arr[STG_DEC] == rd_arr[gi])) ||
                 (rs2_u_arr[STG_DEC] && (rs2_arr[STG_DEC] == rd_arr[gi])));
        end
    endgenerate

    logic ex_is_load;
    assign ex_is_load = (ex_ir[6:0] == OPC_LOAD);

    // Bubbles needed before the DEC instruction may enter EX
    logic [1:0] bubbles;
    always_comb begin
        bubbles = 2'd0;
        if (FWD_EN) begin
            // WB result is not bypassed into DEC, so a WB producer still costs one cycle
            if ((hit[STG_EX] && ex_is_load) || hit[STG_WB])
                bubbles = 2'd1;
        end else begin
            if (hit[STG_EX])       bubbles = 2'd3;
            else if (hit[STG_MEM]) bubbles = 2'd2;
            else if (hit[STG_WB])  bubbles = 2'd1;
        end
    end

    // Stall FSM
    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        pc_write   = 1'b1;
        dec_en     = 1'b1;
        ex_flush   = 1'b0;
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (rst) begin
            // outputs held at reset values while rst is asserted
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
        end else if (br_flush) begin
            ex_flush   = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
        end else if (state_reg == ST_STALL) begin
            pc_write = 1'b0;
            dec_en   = 1'b0;
            ex_flush = 1'b1;
            cnt_next = cnt_reg - 2'd1;
            if (cnt_reg <= 2'd1)
                state_next = ST_IDLE;
        end else if (bubbles != 2'd0) begin
            pc_write = 1'b0;
            dec_en   = 1'b0;
            ex_flush = 1'b1;
            cnt_next = bubbles - 2'd1;
            if (bubbles > 2'd1)
                state_next = ST_STALL;
        end
    end

    assign stalled = (state_reg == ST_STALL);

    // Forward selects, captured as the DEC instruction moves into EX
    generate
        if (FWD_EN) begin : g_fwd
            fwd_sel_t fwd_a_reg, fwd_b_reg;
            fwd_sel_t fwd_a_next, fwd_b_next;

            always_comb begin
                fwd_a_next = FWD_RF;
                fwd_b_next = FWD_RF;
                if (rs1_u_arr[STG_DEC] && rd_v_arr[STG_EX] && (rs1_arr[STG_DEC] == rd_arr[STG_EX]))
                    fwd_a_next = FWD_MEM;
                else if (rs1_u_arr[STG_DEC] && rd_v_arr[STG_MEM] && (rs1_arr[STG_DEC] == rd_arr[STG_MEM]))
                    fwd_a_next = FWD_WB;
                if (rs2_u_arr[STG_DEC] && rd_v_arr[STG_EX] && (rs2_arr[STG_DEC] == rd_arr[STG_EX]))
                    fwd_b_next = FWD_MEM;
                else if (rs2_u_arr[STG_DEC] && rd_v_arr[STG_MEM] && (rs2_arr[STG_DEC] == rd_arr[STG_MEM]))
                    fwd_b_next = FWD_WB;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fwd_a_reg <= FWD_RF;
                    fwd_b_reg <= FWD_RF;
                end else if (ex_flush) begin
                    fwd_a_reg <= FWD_RF;
                    fwd_b_reg <= FWD_RF;
                end else if (dec_en) begin
                    fwd_a_reg <= fwd_a_next;
                    fwd_b_reg <= fwd_b_next;
                end
            end

            assign fwd_a_sel = fwd_a_reg;
            assign fwd_b_sel = fwd_b_reg;
        end else begin : g_nofwd
            assign fwd_a_sel = 2'd0;
            assign fwd_b_sel = 2'd0;
        end
    endgenerate

    // Saturating stall-cycle counter
    logic [PERF_W-1:0] perf_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_reg <= '0;
        else if (!pc_write && (perf_reg != {PERF_W{1'b1}}))
            perf_reg <= perf_reg + 1'b1;
    end
    assign stall_cycles = perf_reg;

    logic unused_fields;
    assign unused_fields = ^{rs1_arr[STG_EX], rs1_arr[STG_MEM], rs1_arr[STG_WB],
                             rs2_arr[STG_EX], rs2_arr[STG_MEM], rs2_arr[STG_WB],
                             rs1_u_arr[STG_EX], rs1_u_arr[STG_MEM], rs1_u_arr[STG_WB],
                             rs2_u_arr[STG_EX], rs2_u_arr[STG_MEM], rs2_u_arr[STG_WB],
                             rd_arr[STG_DEC], rd_v_arr[STG_DEC], hit[STG_DEC]};

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed bench for otter_hazard_unit: three instances (stall-only, forwarding,
// stall-only with a 2-bit perf counter) share the pipeline-stage inputs.
module tb_otter_hazard_unit;
    import otter_pkg::*;

    localparam logic [31:0] ADDI_X5   = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADD_655   = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] ADD_657   = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] LW_X7     = 32'h0001_2383; // lw   x7,0(x2)
    localparam logic [31:0] LW_X5     = 32'h0001_2283; // lw   x5,0(x2)
    localparam logic [31:0] LW_X0     = 32'h0001_2003; // lw   x0,0(x2)
    localparam logic [31:0] SW_X7     = 32'h0071_A223; // sw   x7,4(x3)
    localparam logic [31:0] ADD_812   = 32'h0020_8433; // add  x8,x1,x2
    localparam logic [31:0] BEQ_80    = 32'h0004_0063; // beq  x8,x0,0
    localparam logic [31:0] ADD_100   = 32'h0000_00B3; // add  x1,x0,x0
    localparam logic [31:0] ADD_644   = 32'h0042_0333; // add  x6,x4,x4
    localparam logic [31:0] LUI_X5    = 32'h1234_52B7; // lui  x5,0x12345
    localparam logic [31:0] JAL_X1    = 32'h0000_00EF; // jal  x1,0
    localparam logic [31:0] CSRRWI_9  = 32'h3002_D4F3; // csrrwi x9,0x300,5
    localparam logic [31:0] CSRRW_95  = 32'h3002_94F3; // csrrw  x9,0x300,x5
    localparam logic [31:0] UNKNOWN   = 32'h0052_837F; // opcode 7'h7F

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dec_ir = NOP_INSTR, ex_ir = NOP_INSTR, mem_ir = NOP_INSTR, wb_ir = NOP_INSTR;
    logic        br_flush = 1'b0;

    logic        pc_write_f0, dec_en_f0, ex_flush_f0, stalled_f0;
    logic [1:0]  fwd_a_f0, fwd_b_f0;
    logic [15:0] stall_cycles_f0;
    logic        pc_write_f1, dec_en_f1, ex_flush_f1, stalled_f1;
    logic [1:0]  fwd_a_f1, fwd_b_f1;
    logic [15:0] stall_cycles_f1;
    logic        pc_write_s, dec_en_s, ex_flush_s, stalled_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  stall_cycles_s;

    always #5 clk = ~clk;

    otter_hazard_unit #(.FWD_EN(1'b0), .REG_AW(5), .PERF_W(16)) u_f0 (
        .clk(clk), .rst(rst), .dec_ir(dec_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
        .br_flush(br_flush), .pc_write(pc_write_f0), .dec_en(dec_en_f0), .ex_flush(ex_flush_f0),
        .fwd_a_sel(fwd_a_f0), .fwd_b_sel(fwd_b_f0), .stalled(stalled_f0), .stall_cycles(stall_cycles_f0));

    otter_hazard_unit #(.FWD_EN(1'b1), .REG_AW(5), .PERF_W(16)) u_f1 (
        .clk(clk), .rst(rst), .dec_ir(dec_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
        .br_flush(br_flush), .pc_write(pc_write_f1), .dec_en(dec_en_f1), .ex_flush(ex_flush_f1),
        .fwd_a_sel(fwd_a_f1), .fwd_b_sel(fwd_b_f1), .stalled(stalled_f1), .stall_cycles(stall_cycles_f1));

    otter_hazard_unit #(.FWD_EN(1'b0), .REG_AW(5), .PERF_W(2)) u_sat (
        .clk(clk), .rst(rst), .dec_ir(dec_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
        .br_flush(br_flush), .pc_write(pc_write_s), .dec_en(dec_en_s), .ex_flush(ex_flush_s),
        .fwd_a_sel(fwd_a_s), .fwd_b_sel(fwd_b_s), .stalled(stalled_s), .stall_cycles(stall_cycles_s));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        br_flush = 1'b0;
        dec_ir   = NOP_INSTR;
        ex_ir    = NOP_INSTR;
        mem_ir   = NOP_INSTR;
        wb_ir    = NOP_INSTR;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] dec, ex, mem, wb;
        int          n0;   // bubbles in stall-only mode
        int          n1;   // bubbles in forwarding mode
        logic [1:0]  a1;   // fwd_a_sel after the edge (forwarding mode)
        logic [1:0]  b1;   // fwd_b_sel after the edge (forwarding mode)
        string       tag;
    } vec_t;

    vec_t vecs[13];

    // one-cycle pipeline advance driven by the chosen instance's enables
    task automatic pipe_step(input bit use_f1, output bit pw, output bit ef);
        bit de;
        @(negedge clk);
        pw = use_f1 ? pc_write_f1 : pc_write_f0;
        ef = use_f1 ? ex_flush_f1 : ex_flush_f0;
        de = use_f1 ? dec_en_f1   : dec_en_f0;
        @(posedge clk);
        #1;
        wb_ir  = mem_ir;
        mem_ir = ex_ir;
        ex_ir  = ef ? NOP_INSTR : dec_ir;
        if (de) dec_ir = NOP_INSTR;
    endtask

    initial begin
        bit pw, ef;
        int cnt_pw, cnt_ef;

        vecs[0]  = '{ADD_655,  ADDI_X5,   NOP_INSTR, NOP_INSTR, 3, 0, 2'd1, 2'd1, "raw_ex"};
        vecs[1]  = '{SW_X7,    LW_X7,     NOP_INSTR, NOP_INSTR, 3, 1, 2'd0, 2'd0, "loaduse_rs2"};
        vecs[2]  = '{BEQ_80,   ADD_812,   NOP_INSTR, NOP_INSTR, 3, 0, 2'd1, 2'd0, "beq_fwd"};
        vecs[3]  = '{ADD_100,  LW_X0,     NOP_INSTR, NOP_INSTR, 0, 0, 2'd0, 2'd0, "x0_prod"};
        vecs[4]  = '{JAL_X1,   LUI_X5,    NOP_INSTR, NOP_INSTR, 0, 0, 2'd0, 2'd0, "lui_jal"};
        vecs[5]  = '{SW_X7,    NOP_INSTR, LW_X7,     NOP_INSTR, 2, 0, 2'd0, 2'd2, "mem_load"};
        vecs[6]  = '{ADD_655,  NOP_INSTR, NOP_INSTR, ADDI_X5,   1, 1, 2'd0, 2'd0, "wb_prod"};
        vecs[7]  = '{ADD_657,  ADDI_X5,   LW_X7,     NOP_INSTR, 3, 0, 2'd1, 2'd2, "ex_mem_mix"};
        vecs[8]  = '{ADD_655,  ADDI_X5,   LW_X5,     NOP_INSTR, 3, 0, 2'd1, 2'd1, "youngest"};
        vecs[9]  = '{CSRRWI_9, ADDI_X5,   NOP_INSTR, NOP_INSTR, 0, 0, 2'd0, 2'd0, "csrrwi"};
        vecs[10] = '{CSRRW_95, ADDI_X5,   NOP_INSTR, NOP_INSTR, 3, 0, 2'd1, 2'd0, "csrrw"};
        vecs[11] = '{UNKNOWN,  ADDI_X5,   NOP_INSTR, NOP_INSTR, 0, 0, 2'd0, 2'd0, "unknown"};
        vecs[12] = '{ADD_644,  SW_X7,     NOP_INSTR, NOP_INSTR, 0, 0, 2'd0, 2'd0, "store_no_rd"};

        // reset values while rst is held
        #2;
        chk("rst_pc_write",  pc_write_f1, 1);
        chk("rst_dec_en",    dec_en_f1, 1);
        chk("rst_ex_flush",  ex_flush_f1, 0);
        chk("rst_fwd_a",     fwd_a_f1, 0);
        chk("rst_fwd_b",     fwd_b_f1, 0);
        chk("rst_stalled",   stalled_f0, 0);
        chk("rst_perf",      stall_cycles_f0, 0);

        // table-driven single-decision checks
        for (int i = 0; i < 13; i++) begin
            do_reset();
            dec_ir = vecs[i].dec;
            ex_ir  = vecs[i].ex;
            mem_ir = vecs[i].mem;
            wb_ir  = vecs[i].wb;
            @(negedge clk);
            chk($sformatf("%s f0_pc_write", vecs[i].tag), pc_write_f0, (vecs[i].n0 == 0));
            chk($sformatf("%s f0_dec_en",   vecs[i].tag), dec_en_f0,   (vecs[i].n0 == 0));
            chk($sformatf("%s f0_ex_flush", vecs[i].tag), ex_flush_f0, (vecs[i].n0 != 0));
            chk($sformatf("%s f1_pc_write", vecs[i].tag), pc_write_f1, (vecs[i].n1 == 0));
            chk($sformatf("%s f1_ex_flush", vecs[i].tag), ex_flush_f1, (vecs[i].n1 != 0));
            @(posedge clk);
            #1;
            chk($sformatf("%s f0_stalled", vecs[i].tag), stalled_f0, (vecs[i].n0 > 1));
            chk($sformatf("%s f1_stalled", vecs[i].tag), stalled_f1, 0);
            chk($sformatf("%s f0_perf", vecs[i].tag), stall_cycles_f0, (vecs[i].n0 != 0));
            chk($sformatf("%s f1_perf", vecs[i].tag), stall_cycles_f1, (vecs[i].n1 != 0));
            chk($sformatf("%s f1_fwd_a", vecs[i].tag), fwd_a_f1, vecs[i].a1);
            chk($sformatf("%s f1_fwd_b", vecs[i].tag), fwd_b_f1, vecs[i].b1);
            chk($sformatf("%s f0_fwd_a", vecs[i].tag), fwd_a_f0, 0);
            chk($sformatf("%s f0_fwd_b", vecs[i].tag), fwd_b_f0, 0);
            $display("vector %0d %s done", i, vecs[i].tag);
        end

        // stall-only: EX producer costs exactly three bubbles
        do_reset();
        dec_ir = ADD_655;
        ex_ir  = ADDI_X5;
        cnt_pw = 0;
        cnt_ef = 0;
        for (int c = 0; c < 6; c++) begin
            pipe_step(1'b0, pw, ef);
            if (!pw) cnt_pw++;
            if (ef)  cnt_ef++;
        end
        chk("seq3_pc_write_cycles", cnt_pw, 3);
        chk("seq3_ex_flush_cycles", cnt_ef, 3);
        chk("seq3_perf", stall_cycles_f0, 3);
        $display("sequence stall3 done");

        // forwarding: load-use on rs2, one bubble, then WB forward
        do_reset();
        dec_ir = SW_X7;
        ex_ir  = LW_X7;
        cnt_pw = 0;
        for (int c = 0; c < 3; c++) begin
            pipe_step(1'b1, pw, ef);
            if (!pw) cnt_pw++;
            if (c == 1) begin
                chk("lu_ex_holds_sw", (ex_ir == SW_X7), 1);
                chk("lu_fwd_b", fwd_b_f1, 2);
                chk("lu_fwd_a", fwd_a_f1, 0);
            end
        end
        chk("lu_stall_cycles", cnt_pw, 1);
        $display("sequence load_use done");

        // branch flush during a stall
        do_reset();
        dec_ir = ADD_655;
        ex_ir  = ADDI_X5;
        @(posedge clk);
        #1;
        chk("br_stalled_before", stalled_f0, 1);
        br_flush = 1'b1;
        @(negedge clk);
        chk("br_pc_write", pc_write_f0, 1);
        chk("br_dec_en",   dec_en_f0, 1);
        chk("br_ex_flush", ex_flush_f0, 1);
        @(posedge clk);
        #1;
        br_flush = 1'b0;
        dec_ir   = NOP_INSTR;
        ex_ir    = NOP_INSTR;
        chk("br_idle_after", stalled_f0, 0);
        chk("br_perf", stall_cycles_f0, 1);
        @(negedge clk);
        chk("br_pc_write_next", pc_write_f0, 1);
        chk("br_ex_flush_next", ex_flush_f0, 0);
        $display("sequence br_flush done");

        // asynchronous reset in the middle of a stall
        do_reset();
        dec_ir = ADD_655;
        ex_ir  = ADDI_X5;
        @(posedge clk);
        #1;
        chk("mr_stalled_before", stalled_f0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_stalled",  stalled_f0, 0);
        chk("mr_pc_write", pc_write_f0, 1);
        chk("mr_dec_en",   dec_en_f0, 1);
        chk("mr_ex_flush", ex_flush_f0, 0);
        chk("mr_perf",     stall_cycles_f0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_fresh_stall", pc_write_f0, 0);
        chk("mr_fresh_idle",  stalled_f0, 0);
        $display("sequence reset_mid_stall done");

        // counter saturation with a 2-bit counter
        do_reset();
        dec_ir = ADD_655;
        ex_ir  = ADDI_X5;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_perf2", stall_cycles_s, 3);
        chk("sat_perf16", stall_cycles_f0, 5);
        $display("sequence saturation done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
